sram_arb: RTL
=============

SRAM_ARB -- requirements
Module: sram_arb

Interface
REQ-001 Parameter: ADR_W, 8, SRAM word-address width (256 x 32-bit words).
REQ-002 Parameter: DAT_W, 32, data width; write-strobe width is DAT_W/8.
REQ-003 Parameter: MAX_HOLD, 4, maximum consecutive locked grants to one master while the other master is requesting.
REQ-004 The block SHALL have these ports:
- clock  in  1  single clock; all flops on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- io_mN_req  in  1  master N (N=0,1) access request.
- io_mN_lock  in  1  master N asks to keep ownership next cycle.
- io_mN_we  in  1  1 = write, 0 = read.
- io_mN_wstrb  in  4  byte enables for writes.
- io_mN_adr  in  ADR_W  word address.
- io_mN_wdata  in  DAT_W  write data.
- io_mN_gnt  out  1  request accepted this cycle.
- io_mN_rvalid  out  1  read data valid.
- io_mN_rdata  out  DAT_W  read data.
- io_sram_cen  out  1  SRAM chip enable, active-low.
- io_sram_wen  out  1  SRAM write enable, active-low.
- io_sram_wstrb  out  4  SRAM byte enables.
- io_sram_adr  out  ADR_W  SRAM address.
- io_sram_d  out  DAT_W  SRAM write data.
- io_sram_q  in  DAT_W  SRAM read data, valid in the cycle after the sampling edge.

Function
REQ-005 The block SHALL assert at most one io_mN_gnt per cycle. io_mN_gnt is combinational from the req inputs and arbiter state, and is asserted only when io_mN_req=1.
REQ-006 A transfer occurs when req=1 and gnt=1 in the same cycle. The master holds req, we, adr, wdata and wstrb stable until it sees gnt.
REQ-007 A transfer granted in cycle T SHALL be registered onto the io_sram_* outputs for exactly cycle T+1:
- cen=0; wen = ~we; wstrb, adr and d copied from the granted master.
- In any cycle with no grant: cen=1, wen=1, wstrb=0.
REQ-008 For a read granted in cycle T, the owner's io_mN_rvalid SHALL be 1 in cycle T+2, with io_mN_rdata = io_sram_q. A 2-deep owner/read tag pipeline tracks this.
REQ-009 io_mN_rdata SHALL be 0 whenever io_mN_rvalid=0. Writes SHALL never produce rvalid.
REQ-010 Back-to-back grants SHALL be sustained at one per cycle; reads and writes may interleave freely. Throughput is 1 access per cycle.
REQ-011 The arbiter SHALL be an FSM with three states:
- IDLE: no owner.
- OWN0: master 0 holds the lock.
- OWN1: master 1 holds the lock.
REQ-012 FSM transitions:
- A grant with lock=1 enters or stays in OWNN.
- A grant with lock=0, or a cycle with no grant, returns to IDLE.
REQ-013 In OWNN, master N SHALL win regardless of the other request, while hold_cnt < MAX_HOLD.
REQ-014 hold_cnt SHALL:
- increment on each consecutive locked grant to the same master while the other master is requesting;
- reset to 0 on leaving OWNN, or whenever the other master is idle.
REQ-015 When hold_cnt = MAX_HOLD and the other master is requesting, the lock SHALL be broken:
- the other master is granted;
- the FSM goes to IDLE, or to the other OWN state if that master asserts lock.
REQ-016 With a single requester, that requester SHALL be granted every cycle it requests, locked or not.
REQ-017 A write followed by a read of the same address in the next cycle SHALL return the written data. This needs no forwarding, because SRAM ordering is preserved.

Reset
REQ-018 While reset=0, the block SHALL hold these values:
- gnt=0, rvalid=0, rdata=0.
- io_sram_cen=1, io_sram_wen=1, io_sram_wstrb=0, io_sram_adr=0, io_sram_d=0.
- FSM=IDLE, hold_cnt=0, round-robin pointer favours master 0, tag pipeline cleared.
REQ-019 Reset asserted mid-operation SHALL abort the access in flight. No rvalid SHALL be produced for any read granted before reset.

Configuration
REQ-020 With macro SRAM_ARB_RR_EN defined, IDLE-state contention SHALL resolve round-robin:
- the pointer flips to the other master after every grant;
- on simultaneous requests, the master not granted last wins.
REQ-021 Without SRAM_ARB_RR_EN, IDLE-state contention SHALL resolve as fixed priority, with master 0 winning. Lock and MAX_HOLD behaviour SHALL be identical in both builds.

Verification
REQ-022 Master 0 writes adr 0x10, wstrb 4'b0011, data 0xAABBCCDD over stored 0x12345678; next cycle it reads adr 0x10 -> io_m0_rvalid=1 two cycles after the read grant, rdata=0x1234CCDD.
REQ-023 Both masters request reads every cycle, no lock, RR build -> grants alternate m0,m1,m0,...; each master's rvalid arrives exactly T+2 after its own grant; the fixed build grants m0 every cycle.
REQ-024 m0 requests with lock=1 continuously, m1 requests continuously, MAX_HOLD=4 -> m0 is granted 5 consecutive cycles (1 + 4 holds), then m1 is granted.
REQ-025 Idle bus -> io_sram_cen=1, io_sram_wstrb=0 and no gnt; a single m1 write -> io_sram_cen=0 and io_sram_wen=0 for exactly one cycle, one cycle after the grant.
REQ-026 m0 read granted, then reset asserted in the next cycle -> io_m0_rvalid stays 0; after reset release the first contended grant goes to m0.

Source files
------------

// File: rtl/sram_arb.sv
// Two-master arbiter in front of a single-port synchronous SRAM, with bus locking bounded by MAX_HOLD.
// Build option SRAM_ARB_RR_EN: round-robin contention in IDLE; otherwise master 0 has fixed priority.
module sram_arb #(
    parameter int ADR_W    = 8,
    parameter int DAT_W    = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               io_m0_req,
    input  logic               io_m0_lock,
    input  logic               io_m0_we,
    input  logic [DAT_W/8-1:0] io_m0_wstrb,
    input  logic [ADR_W-1:0]   io_m0_adr,
    input  logic [DAT_W-1:0]   io_m0_wdata,
    output logic               io_m0_gnt,
    output logic               io_m0_rvalid,
    output logic [DAT_W-1:0]   io_m0_rdata,
    input  logic               io_m1_req,
    input  logic               io_m1_lock,
    input  logic               io_m1_we,
    input  logic [DAT_W/8-1:0] io_m1_wstrb,
    input  logic [ADR_W-1:0]   io_m1_adr,
    input  logic [DAT_W-1:0]   io_m1_wdata,
    output logic               io_m1_gnt,
    output logic               io_m1_rvalid,
    output logic [DAT_W-1:0]   io_m1_rdata,
    output logic               io_sram_cen,
    output logic               io_sram_wen,
    output logic [DAT_W/8-1:0] io_sram_wstrb,
    output logic [ADR_W-1:0]   io_sram_adr,
    output logic [DAT_W-1:0]   io_sram_d,
    input  logic [DAT_W-1:0]   io_sram_q
);

    localparam int STRB_W = DAT_W / 8;
    localparam int CNT_W  = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_e;

    state_e             state_q;
    state_e             state_d;
    logic [CNT_W-1:0]   hold_cnt_q;
    logic [CNT_W-1:0]   hold_cnt_d;
    logic               gnt0_s;
    logic               gnt1_s;
    logic               any_gnt_s;
    logic               hold_full_s;
    logic               idle_pick1_s;

    logic               sel_we_s;
    logic [STRB_W-1:0]  sel_wstrb_s;
    logic [ADR_W-1:0]   sel_adr_s;
    logic [DAT_W-1:0]   sel_wdata_s;

    logic               cen_q;
    logic               wen_q;
    logic [STRB_W-1:0]  wstrb_q;
    logic [ADR_W-1:0]   adr_q;
    logic [DAT_W-1:0]   d_q;

    // Read tags: stage 1 follows the SRAM command cycle, stage 2 is the data-return cycle.
    logic               t1_vld_q;
    logic               t1_own_q;
    logic               t2_vld_q;
    logic               t2_own_q;

    assign hold_full_s = (hold_cnt_q == CNT_W'(MAX_HOLD));
    assign any_gnt_s   = gnt0_s | gnt1_s;

`ifdef SRAM_ARB_RR_EN
    logic rr_ptr_q;
    logic rr_ptr_d;

    // Round-robin pointer: set means master 1 is favoured on the next IDLE contention.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt0_s) begin
            rr_ptr_d = 1'b1;
        end else if (gnt1_s) begin
            rr_ptr_d = 1'b0;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign idle_pick1_s = rr_ptr_q;
`else
    assign idle_pick1_s = 1'b0;
`endif

    // FSM state register and lock-hold counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // FSM outputs: grant decision; the owner keeps the bus until the hold budget runs out.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (!reset) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else begin
            case (state_q)
                ST_OWN0: begin
                    if (io_m0_req && !(io_m1_req && hold_full_s)) begin
                        gnt0_s = 1'b1;
                    end else if (io_m1_req) begin
                        gnt1_s = 1'b1;
                    end else begin
                        gnt0_s = 1'b0;
                    end
                end
                ST_OWN1: begin
                    if (io_m1_req && !(io_m0_req && hold_full_s)) begin
                        gnt1_s = 1'b1;
                    end else if (io_m0_req) begin
                        gnt0_s = 1'b1;
                    end else begin
                        gnt1_s = 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (io_m0_req && io_m1_req) begin
                        if (idle_pick1_s) begin
                            gnt1_s = 1'b1;
                        end else begin
                            gnt0_s = 1'b1;
                        end
                    end else if (io_m0_req) begin
                        gnt0_s = 1'b1;
                    end else if (io_m1_req) begin
                        gnt1_s = 1'b1;
                    end else begin
                        gnt0_s = 1'b0;
                    end
                end
                default: begin
                    gnt0_s = 1'b0;
                    gnt1_s = 1'b0;
                end
            endcase
        end
    end

    // FSM next state: a locked grant keeps ownership; hold_cnt only counts while the other side waits.
    always_comb begin
        state_d    = ST_IDLE;
        hold_cnt_d = '0;
        if (gnt0_s && io_m0_lock) begin
            state_d = ST_OWN0;
            if (state_q == ST_OWN0 && io_m1_req) begin
                hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end else begin
                hold_cnt_d = '0;
            end
        end else if (gnt1_s && io_m1_lock) begin
            state_d = ST_OWN1;
            if (state_q == ST_OWN1 && io_m0_req) begin
                hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end else begin
                hold_cnt_d = '0;
            end
        end else begin
            state_d    = ST_IDLE;
            hold_cnt_d = '0;
        end
    end

    // Command mux from the granted master.
    always_comb begin
        sel_we_s    = io_m0_we;
        sel_wstrb_s = io_m0_wstrb;
        sel_adr_s   = io_m0_adr;
        sel_wdata_s = io_m0_wdata;
        if (gnt1_s) begin
            sel_we_s    = io_m1_we;
            sel_wstrb_s = io_m1_wstrb;
            sel_adr_s   = io_m1_adr;
            sel_wdata_s = io_m1_wdata;
        end else begin
            sel_we_s    = io_m0_we;
            sel_wstrb_s = io_m0_wstrb;
            sel_adr_s   = io_m0_adr;
            sel_wdata_s = io_m0_wdata;
        end
    end

    // SRAM command register: one cycle of cen per grant; address and data hold otherwise.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cen_q   <= 1'b1;
            wen_q   <= 1'b1;
            wstrb_q <= '0;
            adr_q   <= '0;
            d_q     <= '0;
        end else if (any_gnt_s) begin
            cen_q   <= 1'b0;
            wen_q   <= ~sel_we_s;
            wstrb_q <= sel_wstrb_s;
            adr_q   <= sel_adr_s;
            d_q     <= sel_wdata_s;
        end else begin
            cen_q   <= 1'b1;
            wen_q   <= 1'b1;
            wstrb_q <= '0;
        end
    end

    // Read tag pipeline: clearing it on reset drops any read still in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            t1_vld_q <= 1'b0;
            t1_own_q <= 1'b0;
            t2_vld_q <= 1'b0;
            t2_own_q <= 1'b0;
        end else begin
            t1_vld_q <= any_gnt_s & ~sel_we_s;
            t1_own_q <= gnt1_s;
            t2_vld_q <= t1_vld_q;
            t2_own_q <= t1_own_q;
        end
    end

    assign io_m0_gnt     = gnt0_s;
    assign io_m1_gnt     = gnt1_s;
    assign io_m0_rvalid  = t2_vld_q & ~t2_own_q;
    assign io_m1_rvalid  = t2_vld_q & t2_own_q;
    assign io_m0_rdata   = io_m0_rvalid ? io_sram_q : '0;
    assign io_m1_rdata   = io_m1_rvalid ? io_sram_q : '0;
    assign io_sram_cen   = cen_q;
    assign io_sram_wen   = wen_q;
    assign io_sram_wstrb = wstrb_q;
    assign io_sram_adr   = adr_q;
    assign io_sram_d     = d_q;

endmodule
